mcu_el2_dec_trigger_csr: RTL and testbench

MCU_EL2_DEC_TRIGGER_CSR -- requirements
Module: mcu_el2_dec_trigger_csr

---
 rtl/mcu_el2_dec_trigger_csr_if.sv | 42 ++++
 rtl/mcu_el2_dec_trigger_csr.sv | 117 +++++++++++
 tb/tb_mcu_el2_dec_trigger_csr.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mcu_el2_dec_trigger_csr_if.sv
// Trigger packet type and the CSR/trigger bus between the decode stage
// and the debug trigger CSR block.
package mcu_el2_pkg;
  typedef struct packed {
    logic        select;
    logic        match;
    logic        store;
    logic        load;
    logic        execute;
    logic        m;
    logic [31:0] tdata2;
  } mcu_el2_trigger_pkt_t;
endpackage

interface mcu_el2_dec_trigger_csr_if;
  import mcu_el2_pkg::*;

  logic                            csr_wr_en;
  logic [11:0]                     csr_wr_addr;
  logic [31:0]                     csr_wr_data;
  logic                            csr_rd_en;
  logic [11:0]                     csr_rd_addr;
  logic [31:0]                     csr_rd_data;
  logic                            csr_rd_hit;
  logic                            dbg_mode;
  logic [3:0]                      trigger_hit;
  mcu_el2_trigger_pkt_t [3:0]      trigger_pkt_any;

  modport master (
    output csr_wr_en, csr_wr_addr, csr_wr_data,
    output csr_rd_en, csr_rd_addr,
    output dbg_mode, trigger_hit,
    input  csr_rd_data, csr_rd_hit, trigger_pkt_any
  );

  modport slave (
    input  csr_wr_en, csr_wr_addr, csr_wr_data,
    input  csr_rd_en, csr_rd_addr,
    input  dbg_mode, trigger_hit,
    output csr_rd_data, csr_rd_hit, trigger_pkt_any
  );
endinterface

// File: rtl/mcu_el2_dec_trigger_csr.sv
// Debug trigger CSRs (tselect/mtdata1/mtdata2) for four address/data
// match triggers, plus the per-trigger packet consumed by the match logic.
module mcu_el2_dec_trigger_csr
  import mcu_el2_pkg::*;
#(
  parameter int unsigned NUM_TRIG = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  mcu_el2_dec_trigger_csr_if.slave        bus
);

  localparam logic [11:0] ADDR_TSELECT = 12'h7A0;
  localparam logic [11:0] ADDR_MTDATA1 = 12'h7A1;
  localparam logic [11:0] ADDR_MTDATA2 = 12'h7A2;

  typedef struct packed {
    logic dmode;
    logic hit;
    logic select;
    logic action;
    logic chain;
    logic match;
    logic m;
    logic execute;
    logic store;
    logic load;
  } tcfg_t;

  logic [1:0]                 tsel_q, tsel_d;
  tcfg_t [NUM_TRIG-1:0]       cfg_q, cfg_d;
  logic [NUM_TRIG-1:0][31:0]  tdata2_q, tdata2_d;
  logic [31:0]                rd_data_q;
  logic                       rd_hit_q;

  // Read-only type/maskmax fields are constants folded in at readout.
  function automatic logic [31:0] mt1_word(input tcfg_t c);
    return {4'h2, c.dmode, 6'h1F, c.hit, c.select, 6'b0, c.action, c.chain,
            3'b0, c.match, c.m, 3'b0, c.execute, c.store, c.load};
  endfunction

  always_comb begin
    tsel_d   = tsel_q;
    cfg_d    = cfg_q;
    tdata2_d = tdata2_q;
    if (bus.csr_wr_en && bus.csr_wr_addr == ADDR_TSELECT &&
        bus.csr_wr_data[31:2] == '0)
      tsel_d = bus.csr_wr_data[1:0];
    for (int unsigned i = 0; i < NUM_TRIG; i++) begin
      if (bus.trigger_hit[i])
        cfg_d[i].hit = 1'b1;
      // A debug-owned trigger is locked against writes from outside debug mode.
      if (bus.csr_wr_en && 32'(tsel_q) == i &&
          !(cfg_q[i].dmode && !bus.dbg_mode)) begin
        if (bus.csr_wr_addr == ADDR_MTDATA1) begin
          cfg_d[i].dmode   = bus.csr_wr_data[27] & bus.dbg_mode;
          cfg_d[i].hit     = bus.csr_wr_data[20];
          cfg_d[i].select  = bus.csr_wr_data[19];
          cfg_d[i].action  = bus.csr_wr_data[12] & bus.csr_wr_data[27] & bus.dbg_mode;
          cfg_d[i].chain   = bus.csr_wr_data[11] & (i % 2 == 0);
          cfg_d[i].match   = bus.csr_wr_data[7];
          cfg_d[i].m       = bus.csr_wr_data[6];
          cfg_d[i].execute = bus.csr_wr_data[2];
          cfg_d[i].store   = bus.csr_wr_data[1];
          cfg_d[i].load    = bus.csr_wr_data[0];
        end
        if (bus.csr_wr_addr == ADDR_MTDATA2)
          tdata2_d[i] = bus.csr_wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tsel_q   <= '0;
      cfg_q    <= '0;
      tdata2_q <= '0;
    end else begin
      tsel_q   <= tsel_d;
      cfg_q    <= cfg_d;
      tdata2_q <= tdata2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_hit_q  <= 1'b0;
    end else if (bus.csr_rd_en) begin
      case (bus.csr_rd_addr)
        ADDR_TSELECT: begin rd_data_q <= {30'b0, tsel_q};          rd_hit_q <= 1'b1; end
        ADDR_MTDATA1: begin rd_data_q <= mt1_word(cfg_q[tsel_q]);  rd_hit_q <= 1'b1; end
        ADDR_MTDATA2: begin rd_data_q <= tdata2_q[tsel_q];         rd_hit_q <= 1'b1; end
        default:      begin rd_data_q <= '0;                       rd_hit_q <= 1'b0; end
      endcase
    end
  end

  assign bus.csr_rd_data = rd_data_q;
  assign bus.csr_rd_hit  = rd_hit_q;

  always_comb begin
    bus.trigger_pkt_any = '0;
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_TRIG; i++) begin
        bus.trigger_pkt_any[i].select  = cfg_q[i].select;
        bus.trigger_pkt_any[i].match   = cfg_q[i].match;
        bus.trigger_pkt_any[i].store   = cfg_q[i].store   & ~(cfg_q[i].dmode & bus.dbg_mode);
        bus.trigger_pkt_any[i].load    = cfg_q[i].load    & ~(cfg_q[i].dmode & bus.dbg_mode);
        bus.trigger_pkt_any[i].execute = cfg_q[i].execute & ~(cfg_q[i].dmode & bus.dbg_mode);
        bus.trigger_pkt_any[i].m       = cfg_q[i].m       & ~(cfg_q[i].dmode & bus.dbg_mode);
        bus.trigger_pkt_any[i].tdata2  = tdata2_q[i];
      end
    end
  end

endmodule

// File: tb/tb_mcu_el2_dec_trigger_csr.sv
// Bench for the debug trigger CSR block: word-level reference model checked
// every cycle, plus directed reads with literal expected values.
module tb_mcu_el2_dec_trigger_csr;
  import mcu_el2_pkg::*;

  localparam logic [31:0] MT1_RST  = 32'h23E0_0000;
  localparam logic [31:0] MT1_MASK = 32'h0818_18C7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mcu_el2_dec_trigger_csr_if bus();

  mcu_el2_dec_trigger_csr #(.NUM_TRIG(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [1:0]  m_tsel;
  logic [31:0] m_mt1 [4];
  logic [31:0] m_mt2 [4];
  logic [31:0] m_rd;
  logic        m_hit;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic mcu_el2_trigger_pkt_t exp_pkt(input int i);
    mcu_el2_trigger_pkt_t p;
    logic [31:0] w;
    logic gate;
    p = '0;
    if (!rst) begin
      w = m_mt1[i];
      gate = w[27] && bus.dbg_mode;
      p.select  = w[19];
      p.match   = w[7];
      p.store   = w[1] && !gate;
      p.load    = w[0] && !gate;
      p.execute = w[2] && !gate;
      p.m       = w[6] && !gate;
      p.tdata2  = m_mt2[i];
    end
    return p;
  endfunction

  // Model advance for one rising edge, using the inputs held across it.
  task automatic model_step();
    logic [31:0] n1 [4];
    logic [31:0] w;
    int t;
    if (rst) begin
      m_tsel = 2'd0;
      for (int i = 0; i < 4; i++) begin m_mt1[i] = MT1_RST; m_mt2[i] = '0; end
      m_rd = '0; m_hit = 1'b0;
    end else begin
      t = int'(m_tsel);
      if (bus.csr_rd_en) begin
        case (bus.csr_rd_addr)
          12'h7A0: begin m_rd = {30'b0, m_tsel}; m_hit = 1'b1; end
          12'h7A1: begin m_rd = m_mt1[t];        m_hit = 1'b1; end
          12'h7A2: begin m_rd = m_mt2[t];        m_hit = 1'b1; end
          default: begin m_rd = '0;              m_hit = 1'b0; end
        endcase
      end
      n1 = m_mt1;
      for (int i = 0; i < 4; i++)
        if (bus.trigger_hit[i]) n1[i][20] = 1'b1;
      if (bus.csr_wr_en) begin
        if (bus.csr_wr_addr == 12'h7A0) begin
          if (bus.csr_wr_data < 32'd4) m_tsel = bus.csr_wr_data[1:0];
        end else if ((bus.csr_wr_addr == 12'h7A1 || bus.csr_wr_addr == 12'h7A2) &&
                     !(m_mt1[t][27] && !bus.dbg_mode)) begin
          if (bus.csr_wr_addr == 12'h7A2) m_mt2[t] = bus.csr_wr_data;
          else begin
            w = bus.csr_wr_data & MT1_MASK;
            if (!bus.dbg_mode) w[27] = 1'b0;
            if (!w[27]) w[12] = 1'b0;
            if (t % 2 == 1) w[11] = 1'b0;
            n1[t] = MT1_RST | w;
          end
        end
      end
      m_mt1 = n1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_data", 64'(bus.csr_rd_data), 64'(m_rd));
      chk("rd_hit", 64'(bus.csr_rd_hit), 64'(m_hit));
      for (int i = 0; i < 4; i++)
        chk($sformatf("pkt%0d", i), 64'(bus.trigger_pkt_any[i]), 64'(exp_pkt(i)));
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.csr_wr_en = 1'b1; bus.csr_wr_addr = a; bus.csr_wr_data = d;
    cyc();
    bus.csr_wr_en = 1'b0;
  endtask

  task automatic rd(input string name, input logic [11:0] a,
                    input logic [31:0] exp_d, input logic exp_h);
    bus.csr_rd_en = 1'b1; bus.csr_rd_addr = a;
    cyc();
    bus.csr_rd_en = 1'b0;
    chk({name, "_data"}, 64'(bus.csr_rd_data), 64'(exp_d));
    chk({name, "_hit"}, 64'(bus.csr_rd_hit), 64'(exp_h));
  endtask

  initial begin
    rst = 1'b1;
    bus.csr_wr_en = 1'b1; bus.csr_wr_addr = 12'h7A2; bus.csr_wr_data = 32'hFFFF_FFFF;
    bus.csr_rd_en = 1'b0; bus.csr_rd_addr = '0;
    bus.dbg_mode = 1'b0;  bus.trigger_hit = 4'hF;
    cyc();
    chk_en = 1'b1;
    cyc();
    bus.csr_wr_en = 1'b0; bus.trigger_hit = 4'h0;
    rst = 1'b0;
    cyc();

    rd("rst_mt1", 12'h7A1, 32'h23E0_0000, 1'b1);
    rd("rst_mt2", 12'h7A2, 32'h0000_0000, 1'b1);
    cyc();
    chk("hold_data", 64'(bus.csr_rd_data), 64'h0);
    chk("hold_hit", 64'(bus.csr_rd_hit), 64'h1);

    wr(12'h7A0, 32'd2);
    wr(12'h7A2, 32'h8000_0100);
    wr(12'h7A1, 32'h0000_0044);
    chk("t2_exec", 64'(bus.trigger_pkt_any[2].execute), 64'h1);
    chk("t2_m", 64'(bus.trigger_pkt_any[2].m), 64'h1);
    chk("t2_tdata2", 64'(bus.trigger_pkt_any[2].tdata2), 64'h8000_0100);
    chk("t0_zero", 64'(bus.trigger_pkt_any[0]), 64'h0);
    chk("t1_zero", 64'(bus.trigger_pkt_any[1]), 64'h0);
    chk("t3_zero", 64'(bus.trigger_pkt_any[3]), 64'h0);
    rd("t2_mt1", 12'h7A1, 32'h23E0_0044, 1'b1);

    wr(12'h7A0, 32'd5);
    rd("tsel_hold", 12'h7A0, 32'd2, 1'b1);

    bus.dbg_mode = 1'b1;
    wr(12'h7A0, 32'd1);
    wr(12'h7A1, 32'h0800_1044);
    rd("t1_dmode", 12'h7A1, 32'h2BE0_1044, 1'b1);
    chk("t1_exec_gated", 64'(bus.trigger_pkt_any[1].execute), 64'h0);
    bus.dbg_mode = 1'b0;
    cyc();
    chk("t1_exec_open", 64'(bus.trigger_pkt_any[1].execute), 64'h1);
    wr(12'h7A2, 32'hFFFF_FFFF);
    rd("t1_mt2_lock", 12'h7A2, 32'h0, 1'b1);
    wr(12'h7A1, 32'h0);
    rd("t1_mt1_lock", 12'h7A1, 32'h2BE0_1044, 1'b1);

    wr(12'h7A0, 32'd3);
    bus.trigger_hit = 4'b1000;
    wr(12'h7A1, 32'h0);
    bus.trigger_hit = 4'b0000;
    rd("t3_hit_wr", 12'h7A1, 32'h23E0_0000, 1'b1);
    bus.trigger_hit = 4'b1000;
    cyc();
    bus.trigger_hit = 4'b0000;
    rd("t3_hit_set", 12'h7A1, 32'h23F0_0000, 1'b1);

    bus.dbg_mode = 1'b1;
    wr(12'h7A0, 32'd1);
    wr(12'h7A1, 32'h0000_0800);
    rd("t1_chain", 12'h7A1, 32'h23E0_0000, 1'b1);
    bus.dbg_mode = 1'b0;
    wr(12'h7A0, 32'd0);
    wr(12'h7A1, 32'h0000_0800);
    rd("t0_chain", 12'h7A1, 32'h23E0_0800, 1'b1);

    wr(12'h7A1, 32'h0800_1000);
    rd("t0_dmode_nodbg", 12'h7A1, 32'h23E0_0000, 1'b1);

    bus.csr_rd_en = 1'b1; bus.csr_rd_addr = 12'h7A2;
    wr(12'h7A2, 32'h1234_5678);
    bus.csr_rd_en = 1'b0;
    chk("rw_old", 64'(bus.csr_rd_data), 64'h0);
    rd("rw_new", 12'h7A2, 32'h1234_5678, 1'b1);

    rd("miss", 12'h7A3, 32'h0, 1'b0);

    bus.csr_wr_en = 1'b1; bus.csr_wr_addr = 12'h7A2; bus.csr_wr_data = 32'hDEAD_BEEF;
    bus.trigger_hit = 4'hF;
    rst = 1'b1;
    cyc();
    chk("rst_pkt0", 64'(bus.trigger_pkt_any[0]), 64'h0);
    bus.csr_wr_en = 1'b0; bus.trigger_hit = 4'h0;
    rst = 1'b0;
    rd("rst2_mt2", 12'h7A2, 32'h0, 1'b1);
    rd("rst2_tsel", 12'h7A0, 32'h0, 1'b1);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
